// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing constants and the clock-enable divider width.
package pll_rst_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_PLL_RST    = 3'd1,
        ST_SDRAM_PWR  = 3'd2,
        ST_SDRAM_INIT = 3'd3,
        ST_CORE_DLY   = 3'd4,
        ST_RUN        = 3'd5
    } state_e;

    // Default timing, in 48 MHz cycles
    localparam int unsigned LOCK_STABLE_DEF  = 4096;
    localparam int unsigned LOCK_TIMEOUT_DEF = 1048576;
    localparam int unsigned PLL_RST_CYC_DEF  = 16;
    localparam int unsigned SDRAM_PWR_DEF    = 4800;
    localparam int unsigned CORE_DLY_DEF     = 64;

    // Divider producing the 24/12/6 MHz enables
    localparam int unsigned DIV_W = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL locked flag.
// Ports: clk, rst_n (sync, active-low), d (async input), q (synchronized).
module pll_lock_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// Power-up / lock-loss reset sequencer placed after the system PLL.
// Filters pll_locked, sequences SDRAM and core resets, pulses the PLL reset
// when lock never arrives, and generates 24/12/6 MHz clock enables in RUN.
// Ports:
//   clk, rst_n (sync, active-low), pll_locked (async), sdram_init_done
//   pll_rst, sdram_rst, core_rst_n, ready, cen24, cen12, cen6 (registered)
// Build option: PLL_RST_RETRY_EN enables the lock timeout and PLL_RST state;
// without it pll_rst is tied low and WAIT_LOCK waits indefinitely.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = LOCK_STABLE_DEF,
    parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int unsigned PLL_RST_CYC  = PLL_RST_CYC_DEF,
    parameter int unsigned SDRAM_PWR    = SDRAM_PWR_DEF,
    parameter int unsigned CORE_DLY     = CORE_DLY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic sdram_init_done,
    output logic pll_rst,
    output logic sdram_rst,
    output logic core_rst_n,
    output logic ready,
    output logic cen24,
    output logic cen12,
    output logic cen6
);

    localparam int unsigned CNT_MAX = max_u(max_u(max_u(LOCK_STABLE, LOCK_TIMEOUT),
                                                  max_u(PLL_RST_CYC, SDRAM_PWR)), CORE_DLY);
    localparam int unsigned CW = $clog2(CNT_MAX) + 1;

    state_e             state, state_nxt;
    logic               lock_s;
    logic [CW-1:0]      stab_cnt, stab_nxt;
    logic [CW-1:0]      seq_cnt, seq_nxt;
    logic [DIV_W-1:0]   div, div_nxt;
    logic               sdram_rst_nxt, run_nxt;
    logic               cen24_nxt, cen12_nxt, cen6_nxt;
`ifdef PLL_RST_RETRY_EN
    logic [CW-1:0]      tmo_cnt, tmo_nxt;
    logic               pll_rst_nxt;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    pll_lock_sync #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next state, counters and registered-output next values
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        seq_nxt   = seq_cnt;
`ifdef PLL_RST_RETRY_EN
        tmo_nxt   = tmo_cnt;
`endif

        case (state)
            ST_WAIT_LOCK: begin
                stab_nxt = lock_s ? sat_inc(stab_cnt) : '0;
`ifdef PLL_RST_RETRY_EN
                tmo_nxt  = sat_inc(tmo_cnt);
`endif
                // Stability target wins over a coincident timeout
                if (lock_s && (stab_cnt == CW'(LOCK_STABLE - 1))) begin
                    state_nxt = ST_SDRAM_PWR;
                end
`ifdef PLL_RST_RETRY_EN
                else if (tmo_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nxt = ST_PLL_RST;
                end
`endif
            end
`ifdef PLL_RST_RETRY_EN
            ST_PLL_RST: begin
                seq_nxt = sat_inc(seq_cnt);
                if (seq_cnt == CW'(PLL_RST_CYC - 1)) state_nxt = ST_WAIT_LOCK;
            end
`endif
            ST_SDRAM_PWR: begin
                seq_nxt = sat_inc(seq_cnt);
                if (seq_cnt == CW'(SDRAM_PWR - 1)) state_nxt = ST_SDRAM_INIT;
            end
            ST_SDRAM_INIT: begin
                if (sdram_init_done) state_nxt = ST_CORE_DLY;
            end
            ST_CORE_DLY: begin
                seq_nxt = sat_inc(seq_cnt);
                if (seq_cnt == CW'(CORE_DLY - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss after lock was accepted overrides every other transition
        if (!lock_s && (state inside {ST_SDRAM_PWR, ST_SDRAM_INIT, ST_CORE_DLY, ST_RUN})) begin
            state_nxt = ST_WAIT_LOCK;
        end

        // Every state change starts the new state with clean counters
        if (state_nxt != state) begin
            stab_nxt = '0;
            seq_nxt  = '0;
`ifdef PLL_RST_RETRY_EN
            tmo_nxt  = '0;
`endif
        end

        div_nxt       = ((state == ST_RUN) && (state_nxt == ST_RUN)) ? div + DIV_W'(1) : '0;
        run_nxt       = (state_nxt == ST_RUN);
        sdram_rst_nxt = !(state_nxt inside {ST_SDRAM_INIT, ST_CORE_DLY, ST_RUN});
        cen24_nxt     = run_nxt && (div_nxt[0] == 1'b0);
        cen12_nxt     = run_nxt && (div_nxt[1:0] == 2'b00);
        cen6_nxt      = run_nxt && (div_nxt == '0);
`ifdef PLL_RST_RETRY_EN
        pll_rst_nxt   = (state_nxt == ST_PLL_RST);
`endif
    end

    // State, counters and Moore outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_WAIT_LOCK;
            stab_cnt   <= '0;
            seq_cnt    <= '0;
            div        <= '0;
            sdram_rst  <= 1'b1;
            core_rst_n <= 1'b0;
            ready      <= 1'b0;
            cen24      <= 1'b0;
            cen12      <= 1'b0;
            cen6       <= 1'b0;
        end else begin
            state      <= state_nxt;
            stab_cnt   <= stab_nxt;
            seq_cnt    <= seq_nxt;
            div        <= div_nxt;
            sdram_rst  <= sdram_rst_nxt;
            core_rst_n <= run_nxt;
            ready      <= run_nxt;
            cen24      <= cen24_nxt;
            cen12      <= cen12_nxt;
            cen6       <= cen6_nxt;
        end
    end

`ifdef PLL_RST_RETRY_EN
    // Retry path: timeout counter and PLL reset pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            pll_rst <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            pll_rst <= pll_rst_nxt;
        end
    end
`else
    assign pll_rst = 1'b0;
`endif

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Power-up and lock-loss reset sequencer placed directly after the system PLL. It runs on the 48 MHz PLL output and filters the PLL `locked` flag. It sequences the SDRAM and core resets from that flag, and pulses the PLL reset if lock is never reached. Once the core is running, it generates the 24/12/6 MHz clock-enable pulses used by the core.

## Interface

- `LOCK_STABLE`, 4096: consecutive synchronized-locked cycles required before lock is considered good.
- `LOCK_TIMEOUT`, 1048576: cycles spent in WAIT_LOCK before a PLL reset pulse is issued (about 21.8 ms at 48 MHz).
- `PLL_RST_CYC`, 16: width of the `pll_rst` pulse, in cycles.
- `SDRAM_PWR`, 4800: cycles `sdram_rst` is held after lock is good (100 µs at 48 MHz).
- `CORE_DLY`, 64: cycles between `sdram_init_done` and core reset release.
- `clk` in 1: 48 MHz clock (PLL outclk 0). Single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`. Asynchronous to `clk`; synchronized internally.
- `sdram_init_done` in 1: SDRAM controller has finished its init sequence. Level, `clk` domain.
- `pll_rst` out 1: reset request to the PLL.
- `sdram_rst` out 1: active-high SDRAM controller reset.
- `core_rst_n` out 1: active-low core reset.
- `ready` out 1: high only in RUN.
- `cen24`, `cen12`, `cen6` out 1 each: single-cycle clock-enable pulses.

## Operation

- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`.
- States and transitions:
  - WAIT_LOCK:
    - Stability counter increments while `lock_s`=1 and clears when `lock_s`=0.
    - Timeout counter increments every cycle.
    - When the stability counter reaches `LOCK_STABLE` → SDRAM_PWR.
    - When the timeout counter reaches `LOCK_TIMEOUT` (and the stability target was not reached) → PLL_RST.
  - PLL_RST: `pll_rst`=1 for `PLL_RST_CYC` cycles → WAIT_LOCK, with all counters cleared.
  - SDRAM_PWR: `sdram_rst`=1 for `SDRAM_PWR` cycles → SDRAM_INIT.
  - SDRAM_INIT: `sdram_rst`=0; wait for `sdram_init_done`=1 → CORE_DLY.
  - CORE_DLY: count `CORE_DLY` cycles → RUN.
  - RUN: `core_rst_n`=1, `ready`=1, clock enables active.
- Lock loss: `lock_s`=0 in SDRAM_PWR, SDRAM_INIT, CORE_DLY or RUN → WAIT_LOCK on the next edge, with counters cleared. This overrides every other transition in the same cycle.
- Outputs are registered Moore outputs and change on the same edge as the state register.
  - `sdram_rst`=1 in every state except SDRAM_INIT, CORE_DLY and RUN.
  - `core_rst_n`=0 and `ready`=0 outside RUN.
- Clock-enable divider `div[2:0]`:
  - Cleared on RUN entry; increments every cycle in RUN.
  - `cen24`=(`div[0]`==0), `cen12`=(`div[1:0]`==0), `cen6`=(`div`==0).
  - All three are forced to 0 outside RUN.
- Counter width: `$clog2` of the largest parameter plus 1. Counters saturate and never wrap.

## Timing

- Reset values (`rst_n`=0 at an edge):
  - state=WAIT_LOCK, all counters 0.
  - `pll_rst`=0, `sdram_rst`=1, `core_rst_n`=0, `ready`=0, all cen=0.
- `rst_n` overrides every other condition, including mid-sequence and during PLL_RST; the `pll_rst` pulse is cut short.
- Minimum latency from `pll_locked` rising to SDRAM_PWR entry: 2 + `LOCK_STABLE` cycles.
- `sdram_rst` falls exactly `SDRAM_PWR` cycles after SDRAM_PWR entry.
- `core_rst_n` rises `CORE_DLY`+1 cycles after the first cycle with `sdram_init_done`=1.
- First RUN cycle: `cen24`=`cen12`=`cen6`=1.
- Lock loss is seen at the outputs 3 cycles after `pll_locked` falls (2 synchronizer cycles + 1 state edge).
- `sdram_init_done` is ignored outside SDRAM_INIT.

## Configuration

- `PLL_RST_RETRY_EN` defined: the WAIT_LOCK timeout and the PLL_RST state are compiled in, as described above.
- Undefined: the timeout counter and PLL_RST are removed, `pll_rst` is tied to 0, and WAIT_LOCK waits indefinitely. `LOCK_TIMEOUT` and `PLL_RST_CYC` are then unused.

## Structure

- Shared package `pll_rst_pkg` holds:
  - the state enum (WAIT_LOCK, PLL_RST, SDRAM_PWR, SDRAM_INIT, CORE_DLY, RUN);
  - the default parameter constants;
  - the divider width constant (3).
- One sub-module, `pll_lock_sync`: the 2-flop synchronizer with a parameterized reset value of 0.
- FSM, counters and divider live in the top module.

## Test plan

Bench parameters: `LOCK_STABLE`=8, `LOCK_TIMEOUT`=64, `PLL_RST_CYC`=4, `SDRAM_PWR`=10, `CORE_DLY`=3.

1. `pll_locked`=1 from cycle 0 after reset, `sdram_init_done` tied 1.
   - `sdram_rst` falls at cycle 20.
   - `core_rst_n` and `ready` rise at cycle 24.
   - All three cen pulse together at cycle 24; `cen6` pulses at 32 and 40.
2. `pll_locked` held 0, with `PLL_RST_RETRY_EN` defined.
   - `pll_rst` is high for cycles 64–67, then low.
   - The pulse repeats 68 cycles later.
   - `sdram_rst` stays 1 throughout.
3. `pll_locked` toggles 1-for-5 / 0-for-1 repeatedly: the stability counter never completes and the state stays WAIT_LOCK until the timeout.
4. In RUN, drop `pll_locked` for 1 cycle.
   - 3 cycles later: `core_rst_n`=0, `sdram_rst`=1, cen=0.
   - The full sequence reruns after relock.
5. Assert `rst_n`=0 mid-SDRAM_PWR: at the next edge, all outputs take their reset values and state=WAIT_LOCK.
6. `PLL_RST_RETRY_EN` undefined, `pll_locked`=0 for 200 cycles: `pll_rst` stays 0 and state stays WAIT_LOCK.
